// File: rtl/spart_rx.sv
`timescale 1ns / 1ps
// spart_rx: 8N1 serial receiver, oversampled at 16x the baud rate.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   rxd        asynchronous serial line, idle high, LSB first
//   sample_en  single-clk pulse at 16x the baud rate
//   rd_ack     single-clk pulse, consumer has taken data
//   data       last received byte, held until the next load
//   rda        receive data available
//   frame_err  stop bit of the byte in data was sampled low
//   overrun    a byte was loaded while rda was still set
//
// The start bit is qualified at mid-bit (8 ticks after the falling edge is
// seen); every later bit is sampled 16 ticks after the previous sample, so
// data and stop bits are all taken near their centres.
module spart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       sample_en,
  input  logic       rd_ack,
  output logic [7:0] data,
  output logic       rda,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic        rxd_s;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        rda_q, rda_d;
  logic        fe_q, fe_d;
  logic        ovr_q, ovr_d;
  logic        load;

  // Two-flop synchronizer; only rxd_s is used downstream.
  assign rxd_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  // Frame sequencing. Nothing moves between sample_en pulses.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    load    = 1'b0;

    if (sample_en) begin
      unique case (state_q)
        StIdle: begin
          if (!rxd_s) begin
            state_d = StStart;
            tick_d  = 4'd0;
          end
        end

        StStart: begin
          if (tick_q == 4'd7) begin
            // Mid start bit: a high line here was only a glitch.
            tick_d = 4'd0;
            bit_d  = 3'd0;
            if (!rxd_s) begin
              state_d = StData;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end

        StData: begin
          if (tick_q == 4'd15) begin
            tick_d  = 4'd0;
            // LSB arrives first, so shifting right leaves it in bit 0.
            shift_d = {rxd_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = StStop;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end

        StStop: begin
          if (tick_q == 4'd15) begin
            tick_d = 4'd0;
            load   = 1'b1;
            // A low stop bit may be a break; wait for the line to recover
            // before hunting for another start bit.
            if (rxd_s) begin
              state_d = StIdle;
            end else begin
              state_d = StWaitHigh;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end

        StWaitHigh: begin
          if (rxd_s) begin
            state_d = StIdle;
          end
        end

        default: begin
          state_d = StIdle;
          tick_d  = 4'd0;
          bit_d   = 3'd0;
        end
      endcase
    end
  end

  // Consumer-facing holding register and status flags. A load in the same
  // cycle as rd_ack wins: the consumer acknowledged the old byte, so the new
  // one is not an overrun.
  always_comb begin
    data_d = data_q;
    rda_d  = rda_q;
    fe_d   = fe_q;
    ovr_d  = ovr_q;

    if (load) begin
      data_d = shift_q;
      rda_d  = 1'b1;
      fe_d   = ~rxd_s;
      ovr_d  = rda_q & ~rd_ack;
    end else if (rd_ack && rda_q) begin
      rda_d = 1'b0;
      fe_d  = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      rda_q   <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rda_q   <= rda_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data      = data_q;
  assign rda       = rda_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
`timescale 1ns / 1ps
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       sample_en;
  logic       rd_ack;
  logic [7:0] data;
  logic       rda;
  logic       frame_err;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the consumer-visible state.
  logic [7:0] m_data;
  logic       m_rda, m_fe, m_ovr;

  spart_rx dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .sample_en(sample_en),
    .rd_ack   (rd_ack),
    .data     (data),
    .rda      (rda),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // One oversampling tick: idle gap of 2..4 clocks, then a one-clock pulse.
  // Returns 1 time unit after the edge that consumed the pulse.
  task automatic tick(input logic ack);
    int g;
    g = $urandom_range(2, 4);
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    sample_en = 1'b1;
    rd_ack    = ack;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    rd_ack    = 1'b0;
  endtask

  task automatic send_bits(input logic v, input int n);
    rxd = v;
    repeat (n) tick(1'b0);
  endtask

  // Start bit, 8 data bits, then the first half of the stop bit. The next
  // tick is the one on which the byte should be loaded.
  task automatic send_until_load(input logic [7:0] b, input logic stop);
    send_bits(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bits(b[i], 16);
    send_bits(stop, 8);
  endtask

  function automatic void model_load(input logic [7:0] b, input logic stop, input logic ack);
    m_ovr  = m_rda && !ack;
    m_rda  = 1'b1;
    m_fe   = !stop;
    m_data = b;
  endfunction

  task automatic do_ack();
    rd_ack = 1'b1;
    @(posedge clk);
    #1;
    rd_ack = 1'b0;
    if (m_rda) begin
      m_rda = 1'b0;
      m_fe  = 1'b0;
      m_ovr = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; sample_en = 1'b0; rd_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== 11'h000) begin
      n_bad++;
      $display("FAIL reset: got data=%h rda=%b fe=%b ovr=%b, want all zero",
               data, rda, frame_err, overrun);
    end
    send_bits(1'b1, 4);
  endtask

  task automatic test_basic();
    send_until_load(8'hA5, 1'b1);
    n_cmp++;
    if (rda !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_early: got rda=%b before stop sample, want 0", rda);
    end
    tick(1'b0);
    model_load(8'hA5, 1'b1, 1'b0);
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL basic_load: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
    repeat (7) tick(1'b0);
    do_ack();
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL basic_ack: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
  endtask

  task automatic test_glitch();
    send_bits(1'b0, 4);
    send_bits(1'b1, 24);
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL glitch: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
  endtask

  task automatic test_frame_err();
    send_until_load(8'h3C, 1'b0);
    tick(1'b0);
    model_load(8'h3C, 1'b0, 1'b0);
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL ferr_load: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
    // Line stays low (break), then recovers long enough that any frame
    // wrongly started during the low period would have completed.
    send_bits(1'b0, 40);
    send_bits(1'b1, 170);
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL ferr_break: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
    do_ack();
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL ferr_ack: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
    send_until_load(8'h55, 1'b1);
    tick(1'b0);
    model_load(8'h55, 1'b1, 1'b0);
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL ferr_next: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
    repeat (7) tick(1'b0);
    do_ack();
  endtask

  task automatic test_back_to_back();
    send_until_load(8'h11, 1'b1);
    tick(1'b0);
    model_load(8'h11, 1'b1, 1'b0);
    repeat (7) tick(1'b0);
    send_until_load(8'h22, 1'b1);
    tick(1'b0);
    model_load(8'h22, 1'b1, 1'b0);
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL overrun: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
    repeat (7) tick(1'b0);
    do_ack();
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL overrun_ack: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
  endtask

  task automatic test_ack_collision();
    send_until_load(8'h66, 1'b1);
    tick(1'b0);
    model_load(8'h66, 1'b1, 1'b0);
    repeat (7) tick(1'b0);
    send_until_load(8'h77, 1'b1);
    tick(1'b1);
    model_load(8'h77, 1'b1, 1'b1);
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL collide: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
    repeat (7) tick(1'b0);
    do_ack();
    do_ack();
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL idle_ack: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] junk;
    junk = 8'($urandom);
    send_bits(1'b0, 16);
    for (int i = 0; i < 5; i++) send_bits(junk[i], 16);
    send_bits(junk[5], 5);
    rst = 1'b1;
    rxd = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL midrst: got data=%h rda=%b fe=%b ovr=%b, want all zero",
               data, rda, frame_err, overrun);
    end
    send_bits(1'b1, 3);
    send_until_load(8'h0F, 1'b1);
    n_cmp++;
    if (rda !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_spurious: got rda=%b before stop sample, want 0", rda);
    end
    tick(1'b0);
    model_load(8'h0F, 1'b1, 1'b0);
    n_cmp++;
    if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
      n_bad++;
      $display("FAIL midrst_rx: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
               data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
    end
    repeat (7) tick(1'b0);
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop, ack_load;
    for (int n = 0; n < 14; n++) begin
      b        = 8'($urandom);
      stop     = ($urandom_range(0, 3) != 0);
      ack_load = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        n_cmp++;
        if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
          n_bad++;
          $display("FAIL rand_ack[%0d]: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
                   n, data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
        end
      end
      send_until_load(b, stop);
      n_cmp++;
      if (rda !== m_rda) begin
        n_bad++;
        $display("FAIL rand_early[%0d]: got rda=%b before stop sample, want %b", n, rda, m_rda);
      end
      tick(ack_load);
      model_load(b, stop, ack_load);
      n_cmp++;
      if ({data, rda, frame_err, overrun} !== {m_data, m_rda, m_fe, m_ovr}) begin
        n_bad++;
        $display("FAIL rand_load[%0d]: got data=%h rda=%b fe=%b ovr=%b, want data=%h rda=%b fe=%b ovr=%b",
                 n, data, rda, frame_err, overrun, m_data, m_rda, m_fe, m_ovr);
      end
      repeat (7) tick(1'b0);
      // A low stop bit needs the line to return high before the next start.
      send_bits(1'b1, (stop ? 0 : 1) + $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_ack_collision();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have rxd, input, 1, asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-004 SHALL have sample_en, input, 1, single-clk pulse at 16x baud rate.
REQ-005 SHALL have rd_ack, input, 1, single-clk pulse; consumer has taken data.
REQ-006 SHALL have data, output, 8, last received byte, held until next load.
REQ-007 SHALL have rda, output, 1, receive data available.
REQ-008 SHALL have frame_err, output, 1, stop bit of the byte in data sampled low.
REQ-009 SHALL have overrun, output, 1, byte loaded while rda already set.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer (rxd_s); all decisions use rxd_s only.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH, with a 4-bit tick counter and a 3-bit bit counter.
REQ-012 SHALL advance the tick counter only on sample_en; no state transition occurs without sample_en.
REQ-013 IDLE: on sample_en with rxd_s==0 -> START, tick counter cleared.
REQ-014 START: on the 8th sample_en tick (mid-bit), rxd_s==0 -> DATA with counters cleared; rxd_s==1 -> IDLE (false start, no outputs change).
REQ-015 DATA: on every 16th tick, sample rxd_s into bit 7 of the shift register and shift right; after the 8th bit -> STOP.
REQ-016 STOP: on the 16th tick, load shift register into data and set rda; set frame_err to the inverse of the sampled rxd_s.
REQ-017 STOP exit: stop bit 1 -> IDLE; stop bit 0 -> WAIT_HIGH.
REQ-018 WAIT_HIGH: on sample_en with rxd_s==1 -> IDLE; no start detection while in WAIT_HIGH.
REQ-019 rda SHALL assert on the clk edge that samples the stop bit (latency 0 clk after that sample_en).
REQ-020 A load while rda==1 and rd_ack==0 SHALL overwrite data and set overrun.
REQ-021 rd_ack with no load in the same cycle SHALL clear rda, frame_err, and overrun on the next edge.
REQ-022 rd_ack and a load in the same cycle: load wins; rda=1, overrun=0, frame_err per the new stop bit.
REQ-023 rd_ack while rda==0 SHALL have no effect.
REQ-024 Receive SHALL continue back-to-back; IDLE may detect the next start bit on the first sample_en after STOP exit.

Reset
REQ-025 rst SHALL force state IDLE and clear both counters and the shift register.
REQ-026 rst SHALL force data=8'h00, rda=0, frame_err=0, overrun=0, and synchronizer flops to 1.
REQ-027 rst mid-frame SHALL discard the partial byte; rst has priority over all other inputs.

Verification
REQ-028 Send 0xA5 with a valid stop bit at 16x ticks -> rda=1, data=8'hA5, frame_err=0, overrun=0; rd_ack -> rda=0 next clk.
REQ-029 Low glitch on rxd lasting 4 ticks from idle -> returns to IDLE; rda stays 0 and data is unchanged.
REQ-030 Send 0x3C with stop bit 0 and the line held low for 40 ticks, then high, then 0x55 -> first byte gives data=3C with frame_err=1; no frame starts during the low period; then data=55 with frame_err=0.
REQ-031 Send 0x11 then 0x22 back-to-back with no rd_ack -> data=8'h22, rda=1, overrun=1; rd_ack clears all three flags.
REQ-032 rd_ack pulsed on the same clk as the 0x77 stop-bit load while rda=1 -> rda=1, overrun=0, data=8'h77.
REQ-033 Assert rst after bit 4 of a frame, then send 0x0F -> no spurious byte; data=8'h0F is received correctly.
